// File: rtl/seg_595_scan.sv
// Six-digit seven-segment driver: sequential binary-to-BCD, blanking/sign/point
// decode, digit scan and 14-bit serialisation into a 74HC595 chain.
module seg_595_scan #(
  parameter int CNT_MAX = 49_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        sign,
  input  logic        seg_en,
  output logic        ds,
  output logic        shcp,
  output logic        stcp,
  output logic        oe
);

  localparam logic [1:0]  IDLE    = 2'd0;
  localparam logic [1:0]  SHIFT   = 2'd1;
  localparam logic [1:0]  DONE    = 2'd2;
  localparam int          DW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [19:0] VAL_MAX = 20'd999_999;

  logic [1:0]    state;
  logic [4:0]    iter;
  logic [43:0]   dd;
  logic [19:0]   last_val;
  logic          first;
  logic [23:0]   disp_bcd;
  logic          disp_valid;
  logic [19:0]   sat_val;
  logic [DW-1:0] cnt_dwell;
  logic [2:0]    idx;
  logic [5:0]    sel;
  logic [3:0]    digit;
  logic [2:0]    msd;
  logic [7:0]    seg_code;
  logic [13:0]   frame_word;
  logic [13:0]   shadow;
  logic [1:0]    cnt_4;
  logic [3:0]    cnt_bit;
  logic          frame_start;

  assign sat_val = (data > VAL_MAX) ? VAL_MAX : data;

  // One double-dabble iteration on {bcd[23:0], bin[19:0]}: adjust, then shift.
  function automatic logic [43:0] dd_step(input logic [43:0] s);
    logic [43:0] r;
    // NOTE: blocking assignments are correct here; r is a local temporary, not state.
    r = s;
    for (int i = 0; i < 6; i++) begin
      if (r[20+4*i +: 4] >= 4'd5) r[20+4*i +: 4] = r[20+4*i +: 4] + 4'd3;
    end
    return {r[42:0], 1'b0};
  endfunction

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 8'hC0;
      4'd1:    seg_of = 8'hF9;
      4'd2:    seg_of = 8'hA4;
      4'd3:    seg_of = 8'hB0;
      4'd4:    seg_of = 8'h99;
      4'd5:    seg_of = 8'h92;
      4'd6:    seg_of = 8'h82;
      4'd7:    seg_of = 8'hF8;
      4'd8:    seg_of = 8'h80;
      4'd9:    seg_of = 8'h90;
      default: seg_of = 8'hFF;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      iter       <= 5'd0;
      dd         <= 44'd0;
      last_val   <= 20'd0;
      first      <= 1'b1;
      disp_bcd   <= 24'd0;
      disp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (first || (sat_val != last_val)) begin
            dd       <= {24'd0, sat_val};
            last_val <= sat_val;
            first    <= 1'b0;
            iter     <= 5'd0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          dd   <= dd_step(dd);
          iter <= iter + 5'd1;
          if (iter == 5'd19) state <= DONE;
        end
        DONE: begin
          disp_bcd   <= dd[43:20];
          disp_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_dwell <= '0;
      idx       <= 3'd0;
    end else if (cnt_dwell == DW'(CNT_MAX)) begin
      cnt_dwell <= '0;
      idx       <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      cnt_dwell <= cnt_dwell + 1'b1;
    end
  end

  // Segment code for the digit currently selected by the scan index.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    sel      = 6'd0;
    digit    = 4'd0;
    msd      = 3'd0;
    seg_code = 8'hFF;
    case (idx)
      3'd0:    begin sel = 6'b000001; digit = disp_bcd[3:0];   end
      3'd1:    begin sel = 6'b000010; digit = disp_bcd[7:4];   end
      3'd2:    begin sel = 6'b000100; digit = disp_bcd[11:8];  end
      3'd3:    begin sel = 6'b001000; digit = disp_bcd[15:12]; end
      3'd4:    begin sel = 6'b010000; digit = disp_bcd[19:16]; end
      3'd5:    begin sel = 6'b100000; digit = disp_bcd[23:20]; end
      default: begin sel = 6'd0;      digit = 4'd0;            end
    endcase
    for (int i = 1; i < 6; i++) begin
      if (disp_bcd[4*i +: 4] != 4'd0) msd = 3'(i);
    end
    if (disp_valid) begin
      if (idx <= msd) seg_code = seg_of(digit);
      else if (sign && (disp_bcd[23:20] == 4'd0) && (idx == msd + 3'd1)) seg_code = 8'hBF;
    end
    if (|(point & sel)) seg_code[7] = 1'b0;
  end

  assign frame_word  = {seg_code, sel};
  assign frame_start = (cnt_bit == 4'd0) && (cnt_4 == 2'd0);

  // ds changes at cnt_4 = 0 and shcp is high while the counter reads 3 and 0,
  // giving two cycles of setup and two of hold around each shift edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_4   <= 2'd0;
      cnt_bit <= 4'd0;
      shadow  <= 14'd0;
      ds      <= 1'b0;
      shcp    <= 1'b0;
      stcp    <= 1'b0;
      oe      <= 1'b1;
    end else begin
      cnt_4 <= cnt_4 + 2'd1;
      if (cnt_4 == 2'd3) cnt_bit <= (cnt_bit == 4'd13) ? 4'd0 : cnt_bit + 4'd1;
      if (frame_start) shadow <= frame_word;
      if (cnt_4 == 2'd0) ds <= frame_start ? frame_word[0] : shadow[cnt_bit];
      shcp <= cnt_4[1];
      stcp <= (cnt_bit == 4'd13) && (cnt_4 == 2'd3);
      oe   <= ~seg_en;
    end
  end

endmodule

// File: tb/tb_seg_595_scan.sv
// Scoreboard bench for seg_595_scan: models the 595 chain, decodes latched frames
// and compares them with a decimal-arithmetic reference of the display.
module tb_seg_595_scan;

  localparam int CNT_MAX = 5;
  localparam int FRAME   = 56;

  typedef struct packed {
    logic [47:0] p0;
    logic [47:0] p1;
    logic [47:0] p2;
    logic [1:0]  n;
    logic        first;
  } entry_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [19:0] data = 20'd123;
  logic [5:0]  point = 6'd0;
  logic        sign = 1'b0;
  logic        seg_en = 1'b1;
  logic        ds, shcp, stcp, oe;

  int checks = 0;
  int failures = 0;
  entry_t sb[$];

  seg_595_scan #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .data(data), .point(point),
    .sign(sign), .seg_en(seg_en), .ds(ds), .shcp(shcp), .stcp(stcp), .oe(oe)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] seg_tab(input int unsigned d);
    case (d)
      0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0; 4: return 8'h99;
      5: return 8'h92; 6: return 8'h82; 7: return 8'hF8; 8: return 8'h80; default: return 8'h90;
    endcase
  endfunction

  // Reference display: six codes, digit i in bits [8i+7:8i].
  function automatic logic [47:0] model(input int unsigned v_in, input bit s, input logic [5:0] p);
    int unsigned v, pw;
    int unsigned d[6];
    int msd;
    logic [7:0] c;
    logic [47:0] r;
    v = (v_in > 999_999) ? 999_999 : v_in;
    pw = 1;
    for (int i = 0; i < 6; i++) begin
      d[i] = (v / pw) % 10;
      pw = pw * 10;
    end
    msd = 0;
    for (int i = 1; i < 6; i++) if (d[i] != 0) msd = i;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      if (i <= msd) c = seg_tab(d[i]);
      else if (s && v < 100_000 && i == msd + 1) c = 8'hBF;
      else c = 8'hFF;
      if (p[i]) c[7] = 1'b0;
      r[i*8 +: 8] = c;
    end
    return r;
  endfunction

  function automatic logic [47:0] pick(input entry_t e, input int s);
    case (s)
      0: return e.p0;
      1: return e.p1;
      default: return e.p2;
    endcase
  endfunction

  // Monitor: 595 chain model, timing checks and scoreboard pops on each latch.
  initial begin
    int cyc, frame_no, last_stcp, stage, ei;
    logic [13:0] sr, w;
    logic p_shcp, p_stcp, d1, d2, ds_rise, matched;
    logic [5:0] es;
    entry_t e;
    cyc = 0; frame_no = 0; last_stcp = 0; stage = 0;
    sr = '0; p_shcp = 0; p_stcp = 0; d1 = 0; d2 = 0; ds_rise = 0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        cyc = 0; frame_no = 0; last_stcp = 0;
        sr = '0; p_shcp = 0; p_stcp = 0; d1 = 0; d2 = 0;
      end else begin
        cyc++;
        if (shcp && !p_shcp) begin
          check("ds_setup", {47'd0, (ds == d1) && (d1 == d2)}, 48'd1);
          ds_rise = ds;
          sr = {sr[12:0], ds};
        end
        if (!shcp && p_shcp) check("ds_hold", {47'd0, d1}, {47'd0, ds_rise});
        if (stcp && !p_stcp) begin
          if (last_stcp == 0) check("stcp_first", cyc, FRAME);
          else check("stcp_period", cyc - last_stcp, FRAME);
          last_stcp = cyc;
          for (int b = 0; b < 14; b++) w[b] = sr[13-b];
          ei = ((FRAME * frame_no) / (CNT_MAX + 1)) % 6;
          es = 6'b000001 << ei;
          check("sel", {42'd0, w[5:0]}, {42'd0, es});
          if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.first) stage = 0;
            matched = 0;
            for (int s = stage; s < int'(e.n); s++) begin
              if (!matched && pick(e, s)[ei*8 +: 8] == w[13:6]) begin
                matched = 1;
                stage = s;
              end
            end
            check("seg_frame", {40'd0, w[13:6]}, {40'd0, pick(e, stage)[ei*8 +: 8]});
          end
          frame_no++;
        end
        d2 = d1; d1 = ds; p_shcp = shcp; p_stcp = stcp;
      end
    end
  end

  task automatic push(input logic [47:0] p, input int n);
    for (int i = 0; i < n; i++) sb.push_back('{p0: p, p1: p, p2: p, n: 2'd1, first: 1'b0});
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() > 0 && i < 3000) begin
      @(negedge sys_clk);
      i++;
    end
    check("sb_drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic apply(input logic [19:0] v, input bit s, input logic [5:0] p);
    @(negedge sys_clk);
    data = v; sign = s; point = p;
    repeat (200) @(negedge sys_clk);
    push(model(v, s, p), 12);
    drain();
  endtask

  initial begin
    logic [47:0] px, pa, pb;
    logic [19:0] v;
    int r;
    repeat (3) @(negedge sys_clk);
    check("rst_ds", {47'd0, ds}, 48'd0);
    check("rst_shcp", {47'd0, shcp}, 48'd0);
    check("rst_stcp", {47'd0, stcp}, 48'd0);
    check("rst_oe", {47'd0, oe}, 48'd1);
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b1;

    apply(20'd123, 1'b0, 6'b000000);
    apply(20'd42, 1'b1, 6'b000010);
    apply(20'hFFFFF, 1'b1, 6'b000000);
    apply(20'd0, 1'b1, 6'b000001);
    apply(20'd999_999, 1'b0, 6'b111111);
    apply(20'd99_999, 1'b1, 6'b100000);

    for (int t = 0; t < 8; t++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: v = 20'($urandom_range(0, 9));
        1: v = 20'($urandom_range(0, 99_999));
        2: v = 20'($urandom_range(0, 999_999));
        default: v = 20'($urandom_range(1_000_000, 1_048_575));
      endcase
      apply(v, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
    end

    // Value changes mid-conversion: frames may only progress 7 -> 123 -> 456.
    apply(20'd7, 1'b0, 6'b000000);
    px = model(7, 0, 0); pa = model(123, 0, 0); pb = model(456, 0, 0);
    @(negedge sys_clk);
    data = 20'd123;
    for (int i = 0; i < 4; i++) sb.push_back('{p0: px, p1: pa, p2: pb, n: 2'd3, first: (i == 0)});
    repeat (5) @(negedge sys_clk);
    data = 20'd456;
    drain();
    push(pb, 8);
    drain();

    // Disable: oe follows one cycle later, serialiser keeps running.
    @(negedge sys_clk);
    seg_en = 1'b0;
    @(negedge sys_clk);
    check("oe_off", {47'd0, oe}, 48'd1);
    push(pb, 6);
    drain();
    @(negedge sys_clk);
    seg_en = 1'b1;
    @(negedge sys_clk);
    check("oe_on", {47'd0, oe}, 48'd0);

    // Asynchronous reset mid-frame.
    @(negedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1;
    check("mid_rst_ds", {47'd0, ds}, 48'd0);
    check("mid_rst_shcp", {47'd0, shcp}, 48'd0);
    check("mid_rst_stcp", {47'd0, stcp}, 48'd0);
    check("mid_rst_oe", {47'd0, oe}, 48'd1);
    repeat (3) @(negedge sys_clk);
    #2 sys_rst_n = 1'b1;
    repeat (200) @(negedge sys_clk);
    push(pb, 10);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
